data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Multi-cycle data-memory controller that sits directly downstream of the ALU in the single-cycle datapath and consumes the ALU result as a byte address for lw/sw. It owns a word-addressed data array with a configurable access latency. While an access is outstanding it raises a stall so the PC and register file hold. It returns load data with a one-cycle completion pulse.

## Interface
- DEPTH, 128: number of 32-bit words in the array; power of two, 2..4096.
- LATENCY, 2: cycles spent in ACCESS per aligned request; legal range 1..15.

- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_i  input  1  access request (MemRead | MemWrite); held high by the datapath until done_o.
- we_i  input  1  1 = store, 0 = load; sampled with req_i in IDLE.
- addr_i  input  32  byte address (ALU result); sampled in IDLE.
- wdata_i  input  32  store data (RT value); sampled in IDLE.
- rdata_o  output  32  registered load data; valid while done_o = 1.
- done_o  output  1  one-cycle completion pulse.
- stall_o  output  1  hold PC and register-file write.
- misalign_o  output  1  one-cycle pulse, concurrent with done_o, for an address with addr_i[1:0] != 0.

## Operation
- Word index = addr_i[log2(DEPTH)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH words.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE, req_i = 1, aligned:
  - Latch we_i, index and wdata_i.
  - Load the counter with LATENCY-1.
  - Go to ACCESS.
- IDLE, req_i = 1, misaligned:
  - Set the internal misalign flag.
  - Go to DONE.
  - The array is not touched and rdata_o is set to 0.
- IDLE, req_i = 0: stay in IDLE.
- ACCESS, counter != 0: decrement the counter.
- ACCESS, counter == 0:
  - Store: write the latched data into the array.
  - Load: rdata_o <= mem[index].
  - Go to DONE.
- DONE:
  - done_o = 1; misalign_o = the flag.
  - Go to IDLE unconditionally.
  - req_i is ignored in this cycle.
  - The datapath advances the PC at the end of DONE, so the next instruction's req_i is evaluated in the following IDLE cycle.
- stall_o (combinational):
  - In IDLE: stall_o = req_i.
  - In ACCESS: stall_o = 1.
  - In DONE: stall_o = 0.
- Latched address and data are unaffected by changes on addr_i/wdata_i after sampling.
- rdata_o holds its value until the next load or misaligned completion. A store leaves rdata_o unchanged.

## Timing
- Reset (rst_i = 0, asynchronous):
  - State goes to IDLE; counter = 0; misalign flag = 0.
  - rdata_o = 0, done_o = 0, misalign_o = 0.
  - stall_o then follows req_i.
  - All array words clear to 0.
- Reset mid-ACCESS aborts the access. A store that has not reached counter == 0 is never written.
- Aligned access with req_i rising in cycle 0:
  - stall_o is high in cycles 0..LATENCY.
  - The array update or read happens at the edge ending cycle LATENCY.
  - done_o is high in cycle LATENCY+1, with stall_o = 0 in that cycle.
- Misaligned access: stall_o is high in cycle 0 only; done_o and misalign_o are high in cycle 1.
- Back-to-back requests: minimum spacing is LATENCY+2 cycles, because one IDLE cycle is mandatory after DONE.
- Store followed by load to the same word: the load returns the new data. There is no bypass; the store is fully committed before DONE.

## Test plan
- Reset: assert rst_i = 0 mid-cycle. Required: all outputs 0 immediately, with no clock edge needed. A load of word 5 after release returns 0x00000000.
- Store/load timing, LATENCY = 2: store 0xDEADBEEF to 0x14 with req_i high from cycle 0. Required: stall_o high in cycles 0–2, done_o in cycle 3. A following load from 0x14 yields rdata_o = 0xDEADBEEF in its done cycle.
- Misaligned: load from 0x16. Required: stall_o high for 1 cycle, then done_o = misalign_o = 1 with rdata_o = 0. Word 5 is unchanged.
- Wrap, DEPTH = 128: store 0x12345678 to 0x204, then load from 0x004. Required: the load returns 0x12345678.
- Reset mid-access: store 0xAAAA5555 to 0x40, LATENCY = 4, and drop rst_i in cycle 2. Required: after release, a load from 0x40 returns 0, and no done_o pulse occurs for the aborted store.
- Back-to-back: alternate 10 stores/loads to random aligned addresses at minimum spacing against a reference array. Required: every load matches the reference, and exactly one done_o pulse per request.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Handshake and data bus between the datapath (master) and the
// multi-cycle data-memory controller (slave).
interface data_mem_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        stall_o;
    logic        misalign_o;

    modport master (
        output req_i,
        output we_i,
        output addr_i,
        output wdata_i,
        input  rdata_o,
        input  done_o,
        input  stall_o,
        input  misalign_o
    );

    modport slave (
        input  req_i,
        input  we_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o,
        output done_o,
        output stall_o,
        output misalign_o
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller. Takes the ALU result as a byte
// address, spends LATENCY cycles in ACCESS for aligned requests, stalls the
// datapath meanwhile, and signals completion with a one-cycle done pulse.
// Misaligned addresses skip the array and complete immediately with a
// misalign pulse and zero read data.
module data_mem_ctrl #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    data_mem_ctrl_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_count;
    logic          r_we;
    logic [AW-1:0] r_index;
    logic [31:0]   r_wdata;
    logic          r_misalign;
    logic          r_done;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH];

    logic [AW-1:0] w_index;
    logic          w_misaligned;
    logic          w_commitStore;
    logic          w_stall;
    logic          w_unusedAddr;

    // Word index comes straight from the byte address; upper bits wrap.
    assign w_index      = bus.addr_i[AW+1:2];
    assign w_misaligned = (bus.addr_i[1:0] != 2'b00);
    assign w_unusedAddr = ^bus.addr_i[31:AW+2];

    // The store lands on the last ACCESS cycle, so DONE always sees it committed.
    assign w_commitStore = (r_state == ACCESS) && (r_count == 4'd0) && r_we;

    // Stall follows the request while idle, holds through ACCESS, drops in DONE.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            IDLE:    w_stall = bus.req_i;
            ACCESS:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    // Control FSM: samples the request, counts latency, registers outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_count    <= 4'd0;
            r_we       <= 1'b0;
            r_index    <= '0;
            r_wdata    <= 32'd0;
            r_misalign <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_i) begin
                        if (w_misaligned) begin
                            r_misalign <= 1'b1;
                            r_done     <= 1'b1;
                            r_rdata    <= 32'd0;
                            r_state    <= DONE;
                        end else begin
                            r_we    <= bus.we_i;
                            r_index <= w_index;
                            r_wdata <= bus.wdata_i;
                            r_count <= LAT_INIT;
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        if (!r_we) begin
                            r_rdata <= r_mem[r_index];
                        end
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Data array: cleared on reset, written only when a store completes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_commitStore) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    assign bus.rdata_o    = r_rdata;
    assign bus.done_o     = r_done;
    assign bus.misalign_o = r_misalign;
    assign bus.stall_o    = w_stall;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a driver issues requests and pushes the
// reference model's expected completion; a monitor pops on each done pulse.
module tb_data_mem_ctrl;

    localparam int DEPTH   = 128;
    localparam int LATENCY = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        misalign;
    } expect_t;

    logic clk;
    logic rst;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int          checks;
    int          failures;
    int          issued;
    int          doneSeen;
    bit          pendingDone;
    expect_t     expQ [$];
    logic [31:0] refMem [DEPTH];
    logic [31:0] refLastRdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic refReset();
        for (int i = 0; i < DEPTH; i++) refMem[i] = 32'd0;
        refLastRdata = 32'd0;
    endtask

    // Reference behaviour: what one request should complete with.
    task automatic modelRequest(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        expect_t e;
        int word;
        word = int'((addr >> 2) % DEPTH);
        if (addr[1:0] != 2'b00) begin
            refLastRdata = 32'd0;
            e.misalign = 1'b1;
        end else begin
            e.misalign = 1'b0;
            if (we) refMem[word] = wdata;
            else refLastRdata = refMem[word];
        end
        e.rdata = refLastRdata;
        expQ.push_back(e);
    endtask

    // Issue one request at a negedge and track its stall/done timing.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int  cyc;
        int  expDone;
        bit  stallOk;
        bit  gotDone;
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        modelRequest(we, addr, wdata);
        issued++;
        expDone = (addr[1:0] != 2'b00) ? 1 : LATENCY + 1;
        if (pendingDone) @(negedge clk);
        else #1;
        cyc     = 0;
        stallOk = 1'b1;
        gotDone = 1'b0;
        while (cyc < 40) begin
            if (bus.done_o === 1'b1) begin
                gotDone = 1'b1;
                if (bus.stall_o !== 1'b0) stallOk = 1'b0;
                break;
            end
            if (bus.stall_o !== 1'b1) stallOk = 1'b0;
            if (cyc > 0) begin
                bus.addr_i  = $urandom;
                bus.wdata_i = $urandom;
                bus.we_i    = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, " done_cycle"}, gotDone ? 32'(cyc) : 32'hFFFF_FFFF, 32'(expDone));
        checkOutput({tag, " stall_pattern"}, {31'd0, stallOk}, 32'd1);
        pendingDone = 1'b1;
    endtask

    task automatic idleCycle();
        bus.req_i   = 1'b0;
        pendingDone = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.misalign_o === 1'b1 && bus.done_o !== 1'b1) begin
                checkOutput("misalign_without_done", 32'd1, 32'd0);
            end
            if (bus.done_o === 1'b1) begin
                doneSeen++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    expect_t e;
                    e = expQ.pop_front();
                    checkOutput("rdata", bus.rdata_o, e.rdata);
                    checkOutput("misalign", {31'd0, bus.misalign_o}, {31'd0, e.misalign});
                end
            end
        end
    end

    initial begin
        checks      = 0;
        failures    = 0;
        issued      = 0;
        doneSeen    = 0;
        pendingDone = 1'b0;
        refReset();
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = 32'd0;
        bus.wdata_i = 32'd0;

        // Power-on reset state.
        rst = 1'b0;
        #1;
        checkOutput("reset_rdata", bus.rdata_o, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done_o}, 32'd0);
        checkOutput("reset_misalign", {31'd0, bus.misalign_o}, 32'd0);
        checkOutput("reset_stall", {31'd0, bus.stall_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Store then load the same word.
        applyStimulus(1'b1, 32'h14, 32'hDEADBEEF, "store14");
        idleCycle();
        applyStimulus(1'b0, 32'h14, 32'h0, "load14");
        idleCycle();

        // Misaligned load leaves word 5 alone.
        applyStimulus(1'b0, 32'h16, 32'h0, "misalign16");
        idleCycle();
        applyStimulus(1'b0, 32'h14, 32'h0, "load14_after_mis");
        idleCycle();

        // Address wrap modulo DEPTH words.
        applyStimulus(1'b1, 32'h204, 32'h12345678, "store204");
        idleCycle();
        applyStimulus(1'b0, 32'h004, 32'h0, "load004");
        idleCycle();

        // Asynchronous reset mid-cycle while idle.
        #3;
        rst = 1'b0;
        refReset();
        #1;
        checkOutput("midreset_rdata", bus.rdata_o, 32'd0);
        checkOutput("midreset_done", {31'd0, bus.done_o}, 32'd0);
        checkOutput("midreset_misalign", {31'd0, bus.misalign_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'h14, 32'h0, "load14_after_reset");
        idleCycle();

        // Reset during ACCESS aborts the store.
        applyStimulus(1'b1, 32'h20, 32'h0BADF00D, "store20");
        idleCycle();
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = 32'h40;
        bus.wdata_i = 32'hAAAA5555;
        @(negedge clk);
        #2;
        rst = 1'b0;
        bus.req_i = 1'b0;
        refReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'h40, 32'h0, "load40_after_abort");
        idleCycle();
        applyStimulus(1'b0, 32'h20, 32'h0, "load20_after_abort");
        idleCycle();

        // Back-to-back alternating stores/loads at minimum spacing.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 7)) << 2;
            if (i % 2 == 0) applyStimulus(1'b1, a, $urandom, "b2b_store");
            else            applyStimulus(1'b0, a, 32'h0, "b2b_load");
        end
        idleCycle();

        // Random mix including misaligned and upper-bit-wrapped addresses.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = {22'($urandom_range(0, 3)), 10'($urandom_range(0, 1023))};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            applyStimulus(1'($urandom), a, $urandom, "rand");
            if ($urandom_range(0, 1) == 1) idleCycle();
        end
        idleCycle();

        repeat (5) @(negedge clk);
        checkOutput("done_count", 32'(doneSeen), 32'(issued));
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
